// File: rtl/data_ram_responder.sv
// data_ram_responder: responder end of the ram_port load/store interface.
// Accepts one word load/store at a time, services it from an internal word array after
// LATENCY cycles and returns the response through a valid/ready handshake.
// Optional feature: define DRAM_MISALIGN_CHK_EN to flag misaligned accesses on resp_err
// (misaligned stores then skip the array write and misaligned loads return 0).
module data_ram_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned Words   = 2 ** ADDR_W;
  localparam logic [3:0]  LastCnt = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                accept;
  logic                complete;

  // Request payload captured at acceptance
  logic                we_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [31:0]         wdata_q;
  logic [3:0]          wstrb_q;
  logic                misalign_q;

  logic [31:0]         rdata_q;
  logic                err_q;
  logic [31:0]         mem [Words];

  logic                misalign;

`ifdef DRAM_MISALIGN_CHK_EN
  assign misalign = |req_addr[1:0];
`else
  // Byte offset is ignored: the containing word is accessed.
  assign misalign = 1'b0;
  logic unused_addr_lo;
  assign unused_addr_lo = ^req_addr[1:0];
`endif

  // Address bits above the array index wrap (aliases).
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Next-state, counter and handshake decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    complete  = 1'b0;
    req_ready = (state_q == StIdle) || ((state_q == StResp) && resp_ready);
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StBusy;
          cnt_d   = 4'd0;
        end
      end
      StBusy: begin
        if (cnt_q == LastCnt) begin
          state_d  = StResp;
          complete = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          // A waiting request is taken in the same cycle the response retires.
          if (req_valid) begin
            state_d = StBusy;
            cnt_d   = 4'd0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latch the request so the requester is free to change its inputs afterwards
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q       <= req_we;
      idx_q      <= req_addr[ADDR_W+1:2];
      wdata_q    <= req_wdata;
      wstrb_q    <= req_wstrb;
      misalign_q <= misalign;
    end
  end

  // Response data/error: captured on completion, held until the next completion
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (complete) begin
      rdata_q <= (we_q || misalign_q) ? 32'd0 : mem[idx_q];
      err_q   <= misalign_q;
    end
  end

  // Byte-masked array write; a reset on the completing edge drops the store
  always_ff @(posedge clk) begin
    if (complete && !rst && we_q && !misalign_q) begin
      for (int k = 0; k < 4; k++) begin
        if (wstrb_q[k]) mem[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_ram_responder.sv
// Self-checking bench for data_ram_responder: directed scenarios followed by random
// loads/stores checked against a word-indexed reference memory.
module tb_data_ram_responder;

  localparam int unsigned AW  = 10;
  localparam int unsigned LAT = 2;
`ifdef DRAM_MISALIGN_CHK_EN
  localparam bit Chk = 1'b1;
`else
  localparam bit Chk = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [int unsigned];

  data_ram_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour: expected response for an op, and its effect on memory
  task automatic model_op(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] exp_rd,
                          output logic exp_err);
    int unsigned idx;
    bit mis;
    logic [31:0] w;
    idx     = int'(addr[AW+1:2]);
    mis     = Chk && (addr[1:0] != 2'b00);
    exp_err = mis;
    if (we) begin
      exp_rd = 32'd0;
      if (!mis) begin
        w = model.exists(idx) ? model[idx] : 32'd0;
        for (int k = 0; k < 4; k++) if (strb[k]) w[8*k +: 8] = wdata[8*k +: 8];
        model[idx] = w;
      end
    end else begin
      exp_rd = mis ? 32'd0 : (model.exists(idx) ? model[idx] : 32'd0);
    end
  endtask

  task automatic start_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input string tag);
    bit acc;
    int n;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = strb;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 40) begin
      acc = req_ready;
      tick();
      n++;
    end
    check({tag, " accept"}, 32'(acc), 32'd1);
    // Scramble inputs to prove the request was latched
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wstrb = 4'($urandom);
  endtask

  task automatic wait_resp(input string tag);
    int n;
    n = 0;
    while (!resp_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(LAT));
  endtask

  task automatic end_resp(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int hold, input bit chain,
                          input string tag, output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic        exp_err;
    model_op(we, addr, wdata, strb, exp_rd, exp_err);
    for (int h = 0; h < hold; h++) begin
      check({tag, " hold valid"}, 32'(resp_valid), 32'd1);
      check({tag, " hold rdata"}, resp_rdata, exp_rd);
      check({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
      tick();
    end
    check({tag, " rdata"}, resp_rdata, exp_rd);
    check({tag, " err"}, 32'(resp_err), 32'(exp_err));
    rd = resp_rdata;
    if (!chain) begin
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check({tag, " retire"}, 32'(resp_valid), 32'd0);
    end
  endtask

  task automatic op(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [3:0] strb, input int hold, input string tag,
                    output logic [31:0] rd);
    start_req(we, addr, wdata, strb, tag);
    wait_resp(tag);
    end_resp(we, addr, wdata, strb, hold, 1'b0, tag, rd);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] r;
    logic [9:0]  widx;
    logic [1:0]  lo;
    logic        exp_e;
    logic [31:0] exp_r;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_wstrb  = 4'd0;
    resp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset resp_rdata", resp_rdata, 32'd0);
    check("reset resp_err", 32'(resp_err), 32'd0);

    // Full-word store then load
    op(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 0, "st40", rd);
    op(1'b0, 32'h40, 32'h0, 4'h0, 0, "ld40", rd);
    check("ld40 const", rd, 32'hDEADBEEF);

    // Byte-masked store, then a load held off for 5 cycles
    op(1'b1, 32'h40, 32'h000000AA, 4'b0001, 0, "st40b", rd);
    op(1'b0, 32'h40, 32'h0, 4'h0, 5, "ld40hold", rd);
    check("ld40b const", rd, 32'hDEADBEAA);

    // Aliased load, then a store accepted in the same cycle the response retires
    start_req(1'b0, 32'h0000_1040, 32'h0, 4'h0, "ld1040");
    wait_resp("ld1040");
    end_resp(1'b0, 32'h0000_1040, 32'h0, 4'h0, 0, 1'b1, "ld1040", rd);
    check("ld1040 const", rd, 32'hDEADBEAA);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 32'h44;
    req_wdata  = 32'hCAFE0001;
    req_wstrb  = 4'hF;
    resp_ready = 1'b1;
    #1;
    check("b2b req_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    check("b2b busy", 32'(resp_valid), 32'd0);
    wait_resp("st44");
    end_resp(1'b1, 32'h44, 32'hCAFE0001, 4'hF, 0, 1'b0, "st44", rd);
    op(1'b0, 32'h44, 32'h0, 4'h0, 0, "ld44", rd);
    check("ld44 const", rd, 32'hCAFE0001);

    // Reset on the completing edge of a store drops it
    op(1'b1, 32'h80, 32'h12345678, 4'hF, 0, "st80", rd);
    start_req(1'b1, 32'h80, 32'h11111111, 4'hF, "st80rst");
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst busy resp_valid", 32'(resp_valid), 32'd0);
    check("rst busy req_ready", 32'(req_ready), 32'd1);
    tick();
    check("rst busy idle", 32'(resp_valid), 32'd0);
    op(1'b0, 32'h80, 32'h0, 4'h0, 0, "ld80", rd);
    check("ld80 const", rd, 32'h12345678);

    // Reset while a response is pending discards it (the store itself already committed)
    start_req(1'b1, 32'h84, 32'h5A5A5A5A, 4'hF, "st84");
    wait_resp("st84");
    model_op(1'b1, 32'h84, 32'h5A5A5A5A, 4'hF, exp_r, exp_e);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst resp resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp rdata", resp_rdata, 32'd0);
    op(1'b0, 32'h84, 32'h0, 4'h0, 0, "ld84", rd);

    // Misaligned load
    op(1'b0, 32'h42, 32'h0, 4'h0, 0, "ld42", rd);
    if (Chk) check("ld42 chk", rd, 32'd0);
    else     check("ld42 nochk", rd, 32'hDEADBEAA);

    // Random phase over a 16-word window with random alias bits
    for (int k = 0; k < 16; k++) begin
      r = $urandom;
      op(1'b1, {20'h0, 10'h100 + 10'(k), 2'b00}, r, 4'hF, 0, "fill", rd);
    end
    for (int i = 0; i < 40; i++) begin
      r    = $urandom;
      widx = 10'h100 + 10'(r[11:8]);
      lo   = (r[5:4] == 2'b00) ? r[1:0] : 2'b00;
      op(r[6], {r[31:12], widx, lo}, $urandom, 4'(r[3:0] ^ r[15:12]), int'(r[17:16]),
         "rand", rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
